led_counter_ctrl: RTL and testbench

//   Run/pause/direction controller for the 8-LED binary counter display on the DE0-Nano.

---
 rtl/led_counter_ctrl_if.sv | 9 +
 rtl/led_counter_ctrl.sv | 69 ++++++
 tb/tb_led_counter_ctrl.sv | 118 +++++++++++
 3 files changed

// File: rtl/led_counter_ctrl_if.sv
// led_counter_ctrl_if: key inputs and LED/status outputs of the LED counter controller
interface led_counter_ctrl_if #(parameter int WIDTH = 8);
  logic [1:0]       key_n;
  logic [WIDTH-1:0] led;
  logic             running;
  logic             dir_down;
  modport master(output key_n, input led, running, dir_down);
  modport slave(input key_n, output led, running, dir_down);
endinterface

// File: rtl/led_counter_ctrl.sv
// led_counter_ctrl: debounced run/pause/direction control of a prescaled wrapping up/down LED counter
module led_counter_ctrl #(
  parameter int WIDTH    = 8,
  parameter int TICK_DIV = 25_000_000,
  parameter int DEBOUNCE = 500_000
) (
  input logic             clk,
  input logic             rst,
  led_counter_ctrl_if.slave bus
);
  localparam int TW = $clog2(TICK_DIV);
  localparam int DW = $clog2(DEBOUNCE + 1);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] PAUSE = 2'd2;
  logic [1:0]       sync1_q, sync2_q, deb_q, deb_d, press_evt;
  logic [DW-1:0]    dcnt_q [2];
  logic [DW-1:0]    dcnt_d [2];
  logic [DW-1:0]    inc [2];
  logic [1:0]       state_q, state_d;
  logic [TW-1:0]    tick_q, tick_d;
  logic [WIDTH-1:0] led_q, led_d;
  logic             dir_q, dir_d;
  logic             start_evt, dir_evt, clear, step;
  // Stability counter runs only while the synced level disagrees with the accepted one
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      inc[i]    = dcnt_q[i] + 1'b1;
      deb_d[i]  = (sync2_q[i] != deb_q[i] && inc[i] == DW'(DEBOUNCE)) ? sync2_q[i] : deb_q[i];
      dcnt_d[i] = (sync2_q[i] == deb_q[i] || inc[i] == DW'(DEBOUNCE)) ? '0 : inc[i];
    end
  end
  assign press_evt = deb_q & ~deb_d;
  assign start_evt = press_evt[0];
  assign dir_evt   = press_evt[1];
  assign clear     = start_evt & dir_evt;
  assign step      = state_q == RUN && tick_q == TW'(TICK_DIV - 1);
  // Clear dominates; a step in the same cycle as a start still lands before pausing
  always_comb begin
    state_d = clear ? IDLE : start_evt ? (state_q == RUN ? PAUSE : RUN) : state_q;
    tick_d  = clear ? '0 : state_q != RUN ? tick_q : step ? '0 : tick_q + 1'b1;
    led_d   = clear ? '0 : !step ? led_q : dir_q ? led_q - 1'b1 : led_q + 1'b1;
    dir_d   = clear ? 1'b0 : dir_q ^ dir_evt;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 2'b11;
      sync2_q <= 2'b11;
      deb_q   <= 2'b11;
      dcnt_q  <= '{default: '0};
      state_q <= IDLE;
      tick_q  <= '0;
      led_q   <= '0;
      dir_q   <= 1'b0;
    end else begin
      sync1_q <= bus.key_n;
      sync2_q <= sync1_q;
      deb_q   <= deb_d;
      dcnt_q  <= dcnt_d;
      state_q <= state_d;
      tick_q  <= tick_d;
      led_q   <= led_d;
      dir_q   <= dir_d;
    end
  end
  assign bus.led      = led_q;
  assign bus.running  = state_q == RUN;
  assign bus.dir_down = dir_q;
endmodule

// File: tb/tb_led_counter_ctrl.sv
// tb_led_counter_ctrl: directed key sequences with a cycle-stamped expectation queue
module tb_led_counter_ctrl;
  typedef struct {
    int         at;
    logic [7:0] led;
    logic       run;
    logic       dir;
    string      tag;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   c, d, e;
  exp_t q[$];
  led_counter_ctrl_if #(.WIDTH(8)) bus();
  led_counter_ctrl #(.WIDTH(8), .TICK_DIV(4), .DEBOUNCE(3)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string t, input logic [7:0] l, input logic r, input logic dd);
    checks++;
    assert ({bus.led, bus.running, bus.dir_down} === {l, r, dd}) else begin
      errors++;
      $error("FAIL %s: got led=%0d running=%0b dir_down=%0b, need led=%0d running=%0b dir_down=%0b",
             t, bus.led, bus.running, bus.dir_down, l, r, dd);
    end
  endtask
  task automatic ex(input string t, input int at, input logic [7:0] l, input logic r, input logic dd);
    q.push_back('{at: at, led: l, run: r, dir: dd, tag: t});
  endtask
  task automatic press(input logic [1:0] m, input int hold);
    bus.key_n = ~m;
    repeat (hold) @(negedge clk);
    bus.key_n = 2'b11;
  endtask
  always @(negedge clk) begin
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].at <= cyc) begin
        chk(q[i].tag, q[i].led, q[i].run, q[i].dir);
        q.delete(i);
      end
    end
  end
  initial begin
    bus.key_n = 2'b11;
    #1 rst = 1'b1;
    #1 chk("reset_async", 8'd0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    c = cyc;
    ex("idle_a", c + 2, 8'd0, 1'b0, 1'b0);
    ex("idle_b", c + 6, 8'd0, 1'b0, 1'b0);
    ex("idle_c", c + 10, 8'd0, 1'b0, 1'b0);
    repeat (10) @(negedge clk);
    c = cyc;
    ex("glitch_a", c + 6, 8'd0, 1'b0, 1'b0);
    ex("glitch_b", c + 10, 8'd0, 1'b0, 1'b0);
    bus.key_n[0] = 1'b0;
    repeat (2) @(negedge clk);
    bus.key_n[0] = 1'b1;
    repeat (8) @(negedge clk);
    c = cyc;
    ex("start_early", c + 4, 8'd0, 1'b0, 1'b0);
    ex("start_evt", c + 5, 8'd0, 1'b1, 1'b0);
    ex("pre_step", c + 8, 8'd0, 1'b1, 1'b0);
    ex("step1", c + 9, 8'd1, 1'b1, 1'b0);
    ex("step2", c + 13, 8'd2, 1'b1, 1'b0);
    ex("step3", c + 17, 8'd3, 1'b1, 1'b0);
    ex("paused", c + 19, 8'd3, 1'b0, 1'b0);
    ex("pause_hold_a", c + 30, 8'd3, 1'b0, 1'b0);
    ex("pause_hold_b", c + 44, 8'd3, 1'b0, 1'b0);
    ex("resumed", c + 45, 8'd3, 1'b1, 1'b0);
    ex("resume_wait", c + 46, 8'd3, 1'b1, 1'b0);
    ex("resume_step", c + 47, 8'd4, 1'b1, 1'b0);
    ex("step5", c + 51, 8'd5, 1'b1, 1'b0);
    ex("step10", c + 71, 8'd10, 1'b1, 1'b0);
    ex("pre_clear", c + 74, 8'd10, 1'b1, 1'b0);
    ex("clear", c + 75, 8'd0, 1'b0, 1'b0);
    ex("clear_hold", c + 80, 8'd0, 1'b0, 1'b0);
    press(2'b01, 6);
    repeat (8) @(negedge clk);
    press(2'b01, 6);
    repeat (20) @(negedge clk);
    press(2'b01, 6);
    repeat (24) @(negedge clk);
    press(2'b11, 6);
    repeat (8) @(negedge clk);
    d = cyc;
    ex("dir_idle", d + 5, 8'd0, 1'b0, 1'b1);
    ex("dir_hold", d + 16, 8'd0, 1'b0, 1'b1);
    ex("down_start", d + 17, 8'd0, 1'b1, 1'b1);
    ex("down_pre", d + 20, 8'd0, 1'b1, 1'b1);
    ex("down_wrap", d + 21, 8'd255, 1'b1, 1'b1);
    ex("down_254", d + 25, 8'd254, 1'b1, 1'b1);
    ex("down_254_hold", d + 26, 8'd254, 1'b1, 1'b1);
    press(2'b10, 6);
    repeat (6) @(negedge clk);
    press(2'b01, 6);
    repeat (8) @(negedge clk);
    #2 rst = 1'b1;
    #1 chk("reset_mid_run", 8'd0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    e = cyc;
    ex("post_reset_a", e + 3, 8'd0, 1'b0, 1'b0);
    ex("post_reset_b", e + 8, 8'd0, 1'b0, 1'b0);
    for (int i = 0; i < 50 && q.size() > 0; i++) @(negedge clk);
    @(negedge clk);
    checks++;
    assert (q.size() == 0) else begin
      errors++;
      $error("FAIL drain: got %0d pending expectations, need 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
